// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes a 16-bit, 4-digit display word onto a common-anode
//   seven-segment display. Each digit slot is DIV = CLK_HZ/SCAN_HZ cycles long.
//   The first BLANK_CYC cycles of every slot keep all anodes off so the previous
//   digit cannot ghost into the next one. The display word is captured once per
//   frame, so a mid-frame update never tears the picture.
//
//   Optional feature macro: SEG7_LZ_BLANK_EN enables leading-zero suppression on
//   the captured frame. Digit 0 always displays. A suppressed digit still lights
//   its decimal point, with seg=7F, when its dp bit is set.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   data       in   display word; data[3:0] is the rightmost digit (an[0])
//   dp_in      in   decimal points; dp_in[i]=1 lights the point of digit i
//   an         out  digit anodes, active low (one-hot-low or all high)
//   seg        out  segments {g,f,e,d,c,b,a}, active low
//   dp         out  decimal point, active low
//   frame_done out  1-cycle pulse following the last cycle of the digit-3 slot
module seg7_scan_driver #(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned SCAN_HZ   = 1000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int unsigned DIV  = CLK_HZ / SCAN_HZ;
   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] DivMax   = CntW'(DIV - 1);
   localparam logic [CntW-1:0] BlankLim = CntW'(BLANK_CYC);

   if (BLANK_CYC >= DIV) begin : g_bad_blank
      $fatal(1, "seg7_scan_driver: BLANK_CYC must be less than CLK_HZ/SCAN_HZ");
   end

   typedef enum logic {StBlank, StDrive} state_e;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      unique case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [15:0]     frame_q, frame_d;
   logic [3:0]      dpq_q, dpq_d;
   logic            init_q;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic            fd_q, fd_d;
   logic            wrap;
   logic            snap;
   logic            lz_dark;

   // Slot counter, digit index and per-frame snapshot
   always_comb begin
      wrap  = (cnt_q == DivMax);
      cnt_d = wrap ? '0 : cnt_q + CntW'(1);
      idx_d = wrap ? idx_q + 2'd1 : idx_q;
      // init_q forces a capture on the first cycle out of reset so frame 0 is valid
      snap    = init_q | (wrap & (idx_q == 2'd3));
      frame_d = snap ? data : frame_q;
      dpq_d   = snap ? dp_in : dpq_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         frame_q <= 16'h0000;
         dpq_q   <= 4'h0;
         init_q  <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         dpq_q   <= dpq_d;
         init_q  <= 1'b0;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StBlank;
      else        state_q <= state_d;
   end

   // FSM: next state tracks the counter value being loaded this edge
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBlank: if (cnt_d >= BlankLim) state_d = StDrive;
         StDrive: if (cnt_d < BlankLim)  state_d = StBlank;
         default: state_d = StBlank;
      endcase
   end

`ifdef SEG7_LZ_BLANK_EN
   // Digit i is dark when it and every digit to its left are zero
   always_comb begin
      lz_dark = 1'b0;
      unique case (idx_q)
         2'd3:    lz_dark = (frame_q[15:12] == 4'h0);
         2'd2:    lz_dark = (frame_q[15:8] == 8'h00);
         2'd1:    lz_dark = (frame_q[15:4] == 12'h000);
         default: lz_dark = 1'b0;
      endcase
   end
`else
   assign lz_dark = 1'b0;
`endif

   // FSM: outputs, registered below
   always_comb begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      fd_d  = wrap & (idx_q == 2'd3);
      if (state_q == StDrive) begin
         if (!lz_dark) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = hex7(frame_q[{idx_q, 2'b00} +: 4]);
            dp_d  = ~dpq_q[idx_q];
         end else if (dpq_q[idx_q]) begin
            an_d = ~(4'b0001 << idx_q);
            dp_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q  <= 4'hF;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
         fd_q  <= 1'b0;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
         fd_q  <= fd_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIV=10, BLANK_CYC=2. A timing model keyed on
// the number of clock edges since reset release predicts every output cycle;
// predictions are queued when each clock is driven and popped after the edge.
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] data;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   seg7_scan_driver #(
      .CLK_HZ   (40),
      .SCAN_HZ  (4),
      .BLANK_CYC(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .dp_in     (dp_in),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          k = 0;          // clock edges since reset release
   logic [15:0] m_frame = 16'h0;
   logic [3:0]  m_dp = 4'h0;

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Expected outputs after edge k, from slot position p and digit ix of edge k-1
   function automatic exp_t model(input int p, input int ix);
      exp_t e;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.fd  = (p == 9) && (ix == 3);
      if (p >= 2) begin
         logic       dark;
         logic [3:0] nib;
         dark = 1'b0;
         nib  = 4'(m_frame >> (4 * ix));
`ifdef SEG7_LZ_BLANK_EN
         if (ix > 0 && (m_frame >> (4 * ix)) == 16'h0) dark = 1'b1;
`endif
         if (!dark) begin
            e.an  = 4'hF & ~(4'd1 << ix);
            e.seg = hex_tbl[nib];
            e.dp  = ~m_dp[ix];
         end else if (m_dp[ix]) begin
            e.an = 4'hF & ~(4'd1 << ix);
            e.dp = 1'b0;
         end
      end
      return e;
   endfunction

   task automatic step();
      exp_t e;
      exp_t got;
      if (!rst_n) begin
         e       = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
         m_frame = 16'h0;
         m_dp    = 4'h0;
      end else begin
         k++;
         e = model((k - 1) % 10, ((k - 1) / 10) % 4);
         if (k == 1 || k % 40 == 0) begin
            m_frame = data;
            m_dp    = dp_in;
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      got = '{an: an, seg: seg, dp: dp, fd: frame_done};
      chk($sformatf("an@%0d", k), 7'(got.an), 7'(e.an));
      chk($sformatf("seg@%0d", k), got.seg, e.seg);
      chk($sformatf("dp@%0d", k), 7'(got.dp), 7'(e.dp));
      chk($sformatf("frame_done@%0d", k), 7'(got.fd), 7'(e.fd));
   endtask

   task automatic run_to(input int target);
      while (k < target) step();
   endtask

   initial begin
      rst_n = 1'b0;
      data  = 16'h1234;
      dp_in = 4'h0;
      #1;
      // Held in reset
      for (int i = 0; i < 5; i++) step();

      // Frame 0 with 1234
      rst_n = 1'b1;
      run_to(2);
      chk("blank_slot0", 7'(an), 7'hF);
      run_to(3);
      chk("d0_an", 7'(an), 7'hE);
      chk("d0_seg", seg, 7'h19);
      run_to(13);
      chk("d1_an", 7'(an), 7'hD);
      chk("d1_seg", seg, 7'h30);
      run_to(23);
      chk("d2_an", 7'(an), 7'hB);
      chk("d2_seg", seg, 7'h24);
      run_to(33);
      chk("d3_an", 7'(an), 7'h7);
      chk("d3_seg", seg, 7'h79);
      run_to(40);
      chk("fd_pulse", 7'(frame_done), 7'h1);
      run_to(41);
      chk("fd_clear", 7'(frame_done), 7'h0);

      // Frame 1: data changes during digit-1 drive, must not tear
      run_to(55);
      data = 16'h5678;
      run_to(73);
      chk("no_tear_seg", seg, 7'h79);

      // Frame 2 shows 5678; dp_in changes mid-frame, visible from frame 3
      run_to(83);
      chk("f2_d0_seg", seg, 7'h00);
      run_to(100);
      dp_in = 4'b0100;
      run_to(113);
      chk("f2_d3_seg", seg, 7'h12);
      chk("f2_dp_off", 7'(dp), 7'h1);
      run_to(143);
      chk("f3_dp_an", 7'(an), 7'hB);
      chk("f3_dp_on", 7'(dp), 7'h0);

      // Reset pulse mid-drive of digit 2
      run_to(185);
      chk("pre_rst_an", 7'(an), 7'hB);
      rst_n = 1'b0;
      #1;
      chk("async_rst_an", 7'(an), 7'hF);
      step();
      data  = 16'h0070;
      dp_in = 4'h0;
      k     = 0;
      rst_n = 1'b1;
      run_to(2);
      chk("rst_blank", 7'(an), 7'hF);
      run_to(3);
      chk("rst_d0_an", 7'(an), 7'hE);
      chk("lz_d0_seg", seg, 7'h40);
      run_to(13);
      chk("lz_d1_seg", seg, 7'h78);
      run_to(23);
`ifdef SEG7_LZ_BLANK_EN
      chk("lz_d2_an", 7'(an), 7'hF);
`else
      chk("lz_d2_an", 7'(an), 7'hB);
      chk("lz_d2_seg", seg, 7'h40);
`endif
      // Decimal point on a leading-zero digit
      run_to(30);
      dp_in = 4'b1000;
      run_to(73);
      chk("lz_d3_an", 7'(an), 7'h7);
      chk("lz_d3_dp", 7'(dp), 7'h0);
      run_to(80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
